// File: rtl/vreg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vreg_pkg
// Purpose  : Shared constants for the vector register bank load/store paths:
//            A-field funct codes, store engine state encoding and default
//            bank geometry.
// Revision : 1.0 - initial release
// ============================================================================
package vreg_pkg;

    // Default bank geometry
    localparam int NUM_REGS_DFLT = 16;
    localparam int WORD_W_DFLT   = 32;
    localparam int BUS_W_DFLT    = 128;

    // A[7:5] funct codes, common to the load and store sides
    localparam logic [2:0] FN_SINGLE = 3'b000;
    localparam logic [2:0] FN_QUAD   = 3'b001;
    localparam logic [2:0] FN_FULL   = 3'b010;

    // Store engine state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // True for the funct codes that produce memory beats
    function automatic logic fn_supported(input logic [2:0] funct);
        return (funct == FN_SINGLE) || (funct == FN_QUAD) || (funct == FN_FULL);
    endfunction

endpackage : vreg_pkg
`default_nettype wire

// File: rtl/vreg_beat_mux.sv
`default_nettype none
// ============================================================================
// Module   : vreg_beat_mux
// Purpose  : Combinational beat former. Selects the register words that make
//            up one write beat from a bank snapshot, and produces the byte
//            strobes and last-beat flag for the current beat.
// Revision : 1.0 - initial release
// ============================================================================
module vreg_beat_mux
    import vreg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT,
    parameter int WORD_W   = WORD_W_DFLT,
    parameter int BUS_W    = BUS_W_DFLT,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int BCNT_W   = $clog2(NUM_REGS / (BUS_W / WORD_W))
) (
    input  logic [NUM_REGS*WORD_W-1:0] snapshot,
    input  logic [2:0]                 funct,
    input  logic [IDX_W-1:0]           idx,
    input  logic [BCNT_W-1:0]          beat_cnt,
    output logic [BUS_W-1:0]           wdata,
    output logic [BUS_W/8-1:0]         wstrb,
    output logic                       wlast
);

    localparam int WPB    = BUS_W / WORD_W;   // words per beat
    localparam int WORD_B = WORD_W / 8;       // bytes per word

    localparam logic [BCNT_W-1:0] C_LAST_BEAT = BCNT_W'(NUM_REGS / WPB - 1);

    // One selector per word lane of the beat
    for (genvar k = 0; k < WPB; k++) begin : g_word
        logic [IDX_W-1:0] w_sel_idx;
        logic             w_word_en;

        // Pick the source register for lane k; quad wraps around the bank
        always_comb begin
            w_sel_idx = '0;
            w_word_en = 1'b0;
            case (funct)
                FN_SINGLE: begin
                    w_sel_idx = idx;
                    w_word_en = (k == 0);
                end
                FN_QUAD: begin
                    w_sel_idx = IDX_W'((32'(idx) + 32'(k)) % 32'(NUM_REGS));
                    w_word_en = 1'b1;
                end
                FN_FULL: begin
                    w_sel_idx = IDX_W'((32'(beat_cnt) * 32'(WPB) + 32'(k)) % 32'(NUM_REGS));
                    w_word_en = 1'b1;
                end
                default: begin
                    w_sel_idx = '0;
                    w_word_en = 1'b0;
                end
            endcase
        end

        assign wdata[k*WORD_W +: WORD_W] =
            w_word_en ? snapshot[32'(w_sel_idx) * WORD_W +: WORD_W] : '0;
        assign wstrb[k*WORD_B +: WORD_B] = {WORD_B{w_word_en}};
    end

    // Single and quad stores are one beat; a full store ends on its last beat
    always_comb begin
        wlast = 1'b0;
        case (funct)
            FN_SINGLE: wlast = 1'b1;
            FN_QUAD:   wlast = 1'b1;
            FN_FULL:   wlast = (beat_cnt == C_LAST_BEAT);
            default:   wlast = 1'b0;
        endcase
    end

endmodule : vreg_beat_mux
`default_nettype wire

// File: rtl/vreg_store_engine.sv
`default_nettype none
// ============================================================================
// Module   : vreg_store_engine
// Purpose  : Serialises a 16x32 vector register bank to memory over a 128-bit
//            valid/ready write channel. Supports single-word, quad-word
//            (wrapping) and full-bank stores selected by A[7:5].
// Revision : 1.0 - initial release
// ============================================================================
module vreg_store_engine
    import vreg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DFLT,
    parameter int WORD_W   = WORD_W_DFLT,
    parameter int BUS_W    = BUS_W_DFLT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [7:0]                 req_a,
    input  logic [31:0]                req_addr,
    input  logic [NUM_REGS*WORD_W-1:0] bank_in,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic [31:0]                mem_waddr,
    output logic [BUS_W-1:0]           mem_wdata,
    output logic [BUS_W/8-1:0]         mem_wstrb,
    output logic                       mem_wlast,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WPB    = BUS_W / WORD_W;
    localparam int BCNT_W = $clog2(NUM_REGS / WPB);
    localparam int OFF_W  = $clog2(BUS_W / 8);   // byte offset bits within a beat

    // Control state
    logic [1:0]              r_state;
    logic [2:0]              r_funct;
    logic [IDX_W-1:0]        r_idx;
    logic [31-OFF_W:0]       r_base;
    logic [BCNT_W-1:0]       r_beat_cnt;
    logic                    r_err;

    // Bank contents captured at acceptance
    logic [NUM_REGS*WORD_W-1:0] r_snap;

    logic                    w_accept;
    logic                    w_fn_ok;
    logic                    w_send;
    logic                    w_xfer;
    logic [BUS_W-1:0]        w_wdata;
    logic [BUS_W/8-1:0]      w_wstrb;
    logic                    w_wlast;
    logic [31:0]             w_waddr;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_fn_ok  = fn_supported(req_a[7:5]);
    assign w_send   = (r_state == SEND);
    assign w_xfer   = w_send && mem_wready;

    // FSM and per-request control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_funct    <= FN_SINGLE;
            r_idx      <= '0;
            r_base     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct    <= req_a[7:5];
                        r_idx      <= req_a[IDX_W-1:0];
                        r_base     <= req_addr[31:OFF_W];
                        r_beat_cnt <= '0;
                        r_err      <= !w_fn_ok;
                        r_state    <= w_fn_ok ? SEND : DONE;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_wlast) begin
                            r_state <= DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Snapshot the bank on acceptance; outputs are gated outside SEND so
    // this datapath register carries no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_snap <= bank_in;
        end
    end

    vreg_beat_mux #(
        .NUM_REGS (NUM_REGS),
        .WORD_W   (WORD_W),
        .BUS_W    (BUS_W),
        .IDX_W    (IDX_W),
        .BCNT_W   (BCNT_W)
    ) u_beat_mux (
        .snapshot (r_snap),
        .funct    (r_funct),
        .idx      (r_idx),
        .beat_cnt (r_beat_cnt),
        .wdata    (w_wdata),
        .wstrb    (w_wstrb),
        .wlast    (w_wlast)
    );

    // Beat address: aligned base plus one beat stride per transferred beat
    assign w_waddr = {r_base, {OFF_W{1'b0}}} + (32'(r_beat_cnt) << OFF_W);

    // Write channel is driven only while a beat is pending; zero otherwise
    assign mem_wvalid = w_send;
    assign mem_waddr  = w_send ? w_waddr : '0;
    assign mem_wdata  = w_send ? w_wdata : '0;
    assign mem_wstrb  = w_send ? w_wstrb : '0;
    assign mem_wlast  = w_send && w_wlast;

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = (r_state == DONE) && r_err;

endmodule : vreg_store_engine
`default_nettype wire

// File: doc/vreg_store_engine.md
Name: vreg_store_engine

Overview:
- Read-side counterpart of the WVR/SVR load path: serialises the contents of a 16x32 vector register bank to memory over a 128-bit write channel.
- Uses the same 8-bit A encoding as the register-bank load path: A[7:5] is the function, A[4:0] is the register index.
- Sits between a register bank's flattened 512-bit view and the memory write port. It replaces direct 512-bit transfers with a valid/ready, beat-based protocol.

Parameters:
- NUM_REGS, 16, number of 32-bit registers in the bank.
- WORD_W, 32, register width in bits.
- BUS_W, 128, memory write data width in bits (4 words per beat).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  engine can accept a request; high only in IDLE.
- req_a  in  8  A[7:5] funct (000 single, 001 quad, 010 full); A[4:0] start index.
- req_addr  in  32  memory byte base address.
- bank_in  in  512  flattened bank; register i is at bank_in[i*32 +: 32].
- mem_wvalid  out  1  write beat valid.
- mem_wready  in  1  memory accepts the beat.
- mem_waddr  out  32  beat byte address.
- mem_wdata  out  128  beat data; word k is at [k*32 +: 32].
- mem_wstrb  out  16  byte strobes.
- mem_wlast  out  1  final beat of the request.
- busy  out  1  engine is not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  unsupported funct; valid only while done=1.

Behaviour:
Reset:
- State returns to IDLE.
- req_ready=1 after reset.
- mem_wvalid, mem_wlast, busy, done and err are 0.
- mem_waddr, mem_wdata and mem_wstrb are 0.
- Reset mid-burst abandons the burst with no done pulse. On the next cycle the engine is in IDLE.

States:
- IDLE -> SEND when req_valid & req_ready and funct is in {000, 001, 010}.
- IDLE -> DONE when a request is accepted with any other funct. err=1, and no beats are issued.
- SEND -> DONE on the handshake of the beat with mem_wlast=1.
- DONE -> IDLE after exactly one cycle. done=1 throughout DONE.

Acceptance (cycle T):
- bank_in, req_a and req_addr are snapshotted into internal registers.
- Later changes to bank_in do not affect the request in flight.
- beat_cnt is cleared.

Index:
- idx = req_a[3:0] for all modes (modulo NUM_REGS). req_a[4] is ignored.

Beat formation (first beat mem_wvalid=1 at T+1):
- funct 000: 1 beat; wdata[31:0]=reg[idx]; upper words 0; wstrb=16'h000F.
- funct 001: 1 beat; word k = reg[(idx+k)%16] for k=0..3; wstrb=16'hFFFF. Register indices wrap, e.g. idx=14 gives 14, 15, 0, 1.
- funct 010: 4 beats; beat b, word k = reg[4b+k]; wstrb=16'hFFFF. idx is ignored.

Addressing:
- mem_waddr = {req_addr[31:4], 4'h0} + 16*beat_cnt, computed modulo 2^32.
- Low 4 address bits are forced to zero.

Handshake:
- A beat transfers on a cycle where mem_wvalid & mem_wready.
- While mem_wvalid=1 and mem_wready=0, waddr, wdata, wstrb and wlast hold stable.
- The next beat is presented on the cycle after a transfer. There is no bubble between beats when mem_wready stays high.
- mem_wlast=1 only on the final beat: beat 0 for modes 000/001, beat 3 for mode 010.

Completion:
- done pulses the cycle after the last handshake.
- Minimum latency: request at T, single beat with wready high at T+1, done at T+2, req_ready back at T+3.

Other rules:
- busy = (state != IDLE).
- req_valid outside IDLE is ignored. The request is not accepted and is not queued.
- A request held continuously is accepted once per return to IDLE.

Decomposition:
- Shared package vreg_pkg contains:
  - funct constants FN_SINGLE=3'b000, FN_QUAD=3'b001, FN_FULL=3'b010;
  - the state encoding IDLE/SEND/DONE;
  - NUM_REGS, WORD_W and BUS_W defaults.
- The load-side bank modules use the same funct constants.
- One sub-module: vreg_beat_mux. It is purely combinational: (snapshot, funct, idx, beat_cnt) -> (wdata, wstrb, wlast). It holds the wrap and selection logic so that logic can be tested on its own.

Test Plan:
- Single store: reg5=32'hDEADBEEF, req_a=8'h05, req_addr=32'h1000, wready=1 -> one beat at T+1 with waddr=0x1000, wdata[31:0]=DEADBEEF, upper words 0, wstrb=000F, wlast=1; done at T+2.
- Quad wrap: reg[i]=i+1, req_a=8'h2E (funct 001, idx 14) -> one beat with words {0xF, 0x10, 0x1, 0x2} in order k=0..3; wstrb=FFFF.
- Full store with backpressure: reg[i]=32'hA0+i, req_a=8'h40, req_addr=0x2007, wready low for 3 cycles on beat 1 -> addresses 0x2000, 0x2010, 0x2020, 0x2030; beat 1 holds stable while stalled; wlast only on beat 3; done once.
- Unsupported funct: req_a=8'hE0 -> no mem_wvalid ever; done=1 with err=1 at T+1; req_ready=1 at T+2.
- Snapshot and busy: change bank_in during a full burst, and pulse req_valid while busy -> data matches values at acceptance; second request not accepted; req_ready=0 throughout.
- Reset mid-burst: assert reset during beat 2 of a full store -> next cycle mem_wvalid=0, busy=0, req_ready=1; no done pulse.
